// File: rtl/multiplier_parallel_pkg.sv
// Shared widths and types for the single-cycle 32x32 unsigned multiplier.
package multiplier_parallel_pkg;

  localparam int unsigned OPERAND_W  = 32;
  localparam int unsigned PRODUCT_W  = 64;
  // Eight 3:2 levels take 32 rows down to 2: 32,22,15,10,7,5,4,3,2.
  localparam int unsigned NUM_LEVELS = 8;

  typedef logic [OPERAND_W-1:0] operand_t;
  typedef logic [PRODUCT_W-1:0] product_t;

  // Live row count entering a given reduction level.
  function automatic int unsigned rows_at(input int unsigned level);
    int unsigned n;
    n = OPERAND_W;
    for (int unsigned l = 0; l < level; l++) begin
      n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

endpackage

// File: rtl/multiplier_parallel_unit_csa.sv
// Generic-width 3:2 carry-save compressor; the carry row comes out pre-shifted left by one.
module mp_csa #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  output logic [W-1:0] sum_c,
  output logic [W-1:0] carry_c
);

  logic [W-1:0] maj;

  assign sum_c   = in_a ^ in_b ^ in_c;
  assign maj     = (in_a & in_b) | (in_a & in_c) | (in_b & in_c);
  // The top majority bit would land at bit W and is mathematically zero here.
  assign carry_c = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/multiplier_parallel_unit.sv
// Fully parallel 32x32 unsigned multiplier: carry-save tree, one CPA, registered product.
// Optional operand/product valid handshake under MULTIPLIER_PARALLEL_VALID_EN.
module multiplier_parallel_unit
  import multiplier_parallel_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  operand_t a,
  input  operand_t b,
`ifdef MULTIPLIER_PARALLEL_VALID_EN
  input  logic     valid_in,
  output logic     valid_out,
`endif
  output product_t r
);

  // rows[l][k]: row k entering reduction level l; unused slots are tied to zero.
  product_t rows [0:NUM_LEVELS][0:OPERAND_W-1];
  product_t product_c;
  product_t r_d, r_q;

  for (genvar i = 0; i < OPERAND_W; i++) begin : g_pp
    assign rows[0][i] = b[i] ? (PRODUCT_W'(a) << i) : '0;
  end

  for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_lvl
    localparam int unsigned N   = rows_at(l);
    localparam int unsigned G   = N / 3;
    localparam int unsigned REM = N % 3;

    for (genvar g = 0; g < G; g++) begin : g_csa
      mp_csa #(.W(PRODUCT_W)) u_csa (
        .in_a    (rows[l][3*g]),
        .in_b    (rows[l][3*g+1]),
        .in_c    (rows[l][3*g+2]),
        .sum_c   (rows[l+1][2*g]),
        .carry_c (rows[l+1][2*g+1])
      );
    end

    for (genvar p = 0; p < REM; p++) begin : g_pass
      assign rows[l+1][2*G+p] = rows[l][3*G+p];
    end

    for (genvar z = 2*G + REM; z < OPERAND_W; z++) begin : g_zero
      assign rows[l+1][z] = '0;
    end
  end

  assign product_c = rows[NUM_LEVELS][0] + rows[NUM_LEVELS][1];

`ifdef MULTIPLIER_PARALLEL_VALID_EN
  logic valid_out_d, valid_out_q;

  always_comb begin
    r_d         = r_q;
    valid_out_d = valid_in;
    if (valid_in) begin
      r_d = product_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out_q <= 1'b0;
    end else begin
      valid_out_q <= valid_out_d;
    end
  end

  assign valid_out = valid_out_q;
`else
  always_comb begin
    r_d = product_c;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign r = r_q;

endmodule

// File: tb/tb_multiplier_parallel_unit.sv
// Directed self-checking bench for multiplier_parallel_unit (covers MULTIPLIER_PARALLEL_VALID_EN when defined).
module tb_multiplier_parallel_unit;
  import multiplier_parallel_pkg::*;

  logic     clk = 1'b0;
  logic     reset;
  operand_t a, b;
  product_t r;
`ifdef MULTIPLIER_PARALLEL_VALID_EN
  logic     valid_in;
  logic     valid_out;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  multiplier_parallel_unit dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
`ifdef MULTIPLIER_PARALLEL_VALID_EN
    .valid_in  (valid_in),
    .valid_out (valid_out),
`endif
    .r         (r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input operand_t av, input operand_t bv);
    a = av;
    b = bv;
    step();
  endtask

  operand_t sa, sb;

  initial begin
    reset = 1'b1;
    a     = 32'h1234_5678;
    b     = 32'h9ABC_DEF0;
`ifdef MULTIPLIER_PARALLEL_VALID_EN
    valid_in = 1'b1;
`endif
    step();
    step();
    check("reset_r", r, 64'h0);
`ifdef MULTIPLIER_PARALLEL_VALID_EN
    check("reset_valid_out", 64'(valid_out), 64'h0);
`endif
    reset = 1'b0;

    apply(32'h0, 32'h0);
    check("zero", r, 64'h0);
    apply(32'hDEAD_BEEF, 32'h1);
    check("identity", r, 64'h0000_0000_DEAD_BEEF);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("max", r, 64'hFFFF_FFFE_0000_0001);
    apply(32'h8000_0000, 32'h2);
    check("msb_carry", r, 64'h0000_0001_0000_0000);
    apply(32'h0001_0000, 32'h0001_0000);
    check("pow2_mid", r, 64'h0000_0001_0000_0000);
    apply(32'd12345, 32'd6789);
    check("small", r, 64'd83810205);

    sa = '0;
    sb = '0;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        reset = 1'b1;
        apply(sa, sb);
        check("midreset_r", r, 64'h0);
        reset = 1'b0;
        apply(sa, sb);
        check("after_reset", r, 64'(sa) * 64'(sb));
      end
      apply(sa, sb);
      check("stream", r, 64'(sa) * 64'(sb));
      sa = sa + 32'h2345_6789;
      sb = sb + 32'h3456_7891;
    end

`ifdef MULTIPLIER_PARALLEL_VALID_EN
    valid_in = 1'b1;
    apply(32'd3, 32'd5);
    check("valid_load_r", r, 64'd15);
    check("valid_load_vo", 64'(valid_out), 64'h1);
    valid_in = 1'b0;
    apply(32'd7, 32'd9);
    check("valid_hold_r", r, 64'd15);
    check("valid_hold_vo", 64'(valid_out), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multiplier_parallel_unit.md
# multiplier_parallel_unit

Fully parallel 32x32 unsigned multiplier producing a 64-bit product with a single registered output stage. It generates all 32 partial products at once, reduces them with a carry-save tree and a final carry-propagate adder, then registers the result. It sits in the functional-unit layer as the single-cycle multiply resource, beside the iterative multiplier variants.

## Interface
- No parameters; widths are fixed by package constants (operand 32, product 64).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- a  input  32  unsigned multiplicand.
- b  input  32  unsigned multiplier.
- r  output  64  registered product a*b.
- valid_in  input  1  operand-valid qualifier (present only with MULTIPLIER_PARALLEL_VALID_EN).
- valid_out  output  1  product-valid flag (present only with MULTIPLIER_PARALLEL_VALID_EN).

## Operation
- Partial product i = (b[i] ? a : 0) << i, for i = 0..31, zero-extended to 64 bits.
- Reduce the 32 rows with 3:2 carry-save compressors (Wallace/Dadda style) to two 64-bit rows, then add them with one 64-bit carry-propagate adder.
- The arithmetic is unsigned and the full product is kept: r = {32'b0,a} * {32'b0,b}. No truncation, no overflow flag. The maximum product 0xFFFFFFFE00000001 fits exactly.
- Carries out of bit 63 inside the tree are discarded; they are mathematically zero.
- There is no state machine; the datapath is purely combinational ahead of the r register.

## Timing
- Latency is 1 cycle. Operands stable before rising edge N give r = a*b after edge N.
- r holds its value until the next rising edge. Throughput is one product per cycle.
- Without the valid feature, r updates on every rising edge with no enable.
- Inputs that change mid-cycle have no effect until the next edge.
- On any rising edge with reset=1, r becomes 0 (and valid_out becomes 0). Reset overrides operands and valid_in.
- Reset asserted mid-stream discards the product in flight. The first edge after reset is released captures the current operands normally.
- The whole combinational path (tree plus adder) must close within one clock period. There are no internal pipeline registers.

## Configuration
- MULTIPLIER_PARALLEL_VALID_EN defined:
  - valid_in and valid_out ports exist.
  - r loads only on edges where valid_in=1; otherwise r holds.
  - valid_out is registered: valid_out <= valid_in each edge, cleared by reset.
- MULTIPLIER_PARALLEL_VALID_EN undefined:
  - The ports are absent.
  - r loads unconditionally every edge.

## Structure
- Package multiplier_parallel_pkg holds:
  - OPERAND_W = 32 and PRODUCT_W = 64.
  - typedefs operand_t (logic[31:0]) and product_t (logic[63:0]).
- Sub-module mp_csa: a generic-width 3:2 carry-save compressor. It takes three rows and returns a sum row and a carry row shifted left by 1.
- The top level instantiates the mp_csa reduction levels, the final adder and the output register.

## Test plan
- Reset: hold reset=1 for 2 edges with a=0x12345678, b=0x9ABCDEF0 -> r=0 (valid_out=0).
- Zero and identity:
  - a=0, b=0 -> r=0 one edge later.
  - a=0xDEADBEEF, b=1 -> r=0x00000000DEADBEEF.
- Extremes and carry chain:
  - a=b=0xFFFFFFFF -> r=0xFFFFFFFE00000001.
  - a=0x80000000, b=2 -> r=0x0000000100000000.
- Streaming: start from a=b=0 and each cycle add 0x23456789 to a and 0x34567891 to b, wrapping at 32 bits, for 100 cycles. Each cycle, r must equal the 64-bit product of the operands applied before the preceding edge.
- Reset mid-stream: assert reset for one edge during streaming -> r=0 on that edge. The next edge holds the correct product of the current operands.
- With MULTIPLIER_PARALLEL_VALID_EN, apply a=3, b=5, valid_in=1, then a=7, b=9, valid_in=0:
  - After the first edge: r=15, valid_out=1.
  - After the second edge: r stays 15, valid_out=0.
